// File: rtl/cpu_core_pkg.sv
// Shared definitions for the three-phase 8-bit CPU: widths, instruction
// field positions, opcodes, condition codes, phase encoding and flags.
package cpu_core_pkg;

  localparam int DATA_W    = 8;
  localparam int INSTR_W   = 18;
  localparam int NREGS     = 16;
  localparam int ROM_DEPTH = 16;
  localparam int REG_AW    = 4;
  localparam int PC_W      = 4;

  // Instruction field positions
  localparam int OP_MSB   = 17;
  localparam int OP_LSB   = 14;
  localparam int COND_MSB = 13;
  localparam int COND_LSB = 12;
  localparam int DEST_MSB = 11;
  localparam int DEST_LSB = 8;
  localparam int SRC1_MSB = 7;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_MSB = 3;
  localparam int SRC2_LSB = 0;

  // Opcodes; 1010..1111 are all treated as NOP, OP_NOP is the canonical one
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_ROR = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    COND_GT = 2'b00,
    COND_LT = 2'b01,
    COND_EQ = 2'b10,
    COND_AL = 2'b11
  } cond_e;

  // One-hot phase: bit0 fetch, bit1 decode, bit2 execute
  typedef enum logic [2:0] {
    PH_FETCH = 3'b001,
    PH_DEC   = 3'b010,
    PH_EXEC  = 3'b100
  } phase_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  function automatic logic cond_pass(input cond_e cond, input flags_t f);
    logic ok;
    case (cond)
      COND_GT: ok = !f.z && (f.n == f.v);
      COND_LT: ok = (f.n != f.v);
      COND_EQ: ok = f.z;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // ADD..CMP update flags; everything above CMP is a NOP
  function automatic logic op_sets_flags(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

  // CMP computes flags only, so the register write stops just below it
  function automatic logic op_writes_reg(input logic [3:0] op);
    return op < OP_CMP;
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU plus storage blocks (register file and instruction ROM).
// Shifts use a 16-bit window so the last bit shifted out lands at a fixed
// position, which gives the carry for free for every amount 0..15.
module cpu_alu
  import cpu_core_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        shamt,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);

  logic [DATA_W:0]     sum9;
  logic [DATA_W-1:0]   diff;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] shr_win;
  logic [2*DATA_W-1:0] shl_win;
  logic [2*DATA_W-1:0] ror_win;

  assign sum9    = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;
  assign prod    = {8'b0, a} * {8'b0, b};
  assign shr_win = {a, 8'b0} >> shamt;
  assign shl_win = {8'b0, a} << shamt;
  assign ror_win = {a, a} >> shamt[2:0];

  // Select the result and per-op carry/overflow, then derive N and Z
  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result  = sum9[DATA_W-1:0];
        flags.c = sum9[DATA_W];
        flags.v = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      OP_SUB, OP_CMP: begin
        result  = diff;
        flags.c = (a < b);
        flags.v = (a[7] != b[7]) && (diff[7] != a[7]);
      end
      OP_MUL: begin
        result  = prod[DATA_W-1:0];
        flags.c = |prod[2*DATA_W-1:DATA_W];
        flags.v = |prod[2*DATA_W-1:DATA_W];
      end
      OP_OR:  result = a | b;
      OP_AND: result = a & b;
      OP_XOR: result = a ^ b;
      OP_SHR: begin
        result  = shr_win[2*DATA_W-1:DATA_W];
        flags.c = shr_win[DATA_W-1];
      end
      OP_SHL: begin
        result  = shl_win[DATA_W-1:0];
        flags.c = shl_win[DATA_W];
      end
      OP_ROR: begin
        result  = ror_win[DATA_W-1:0];
        flags.c = ror_win[DATA_W-1];
      end
      default: result = '0;
    endcase
    flags.n = result[DATA_W-1];
    flags.z = (result == '0);
  end

endmodule

// Register file: two combinational read ports, one synchronous write port.
// Contents are deliberately not reset; they are preloaded externally.
module cpu_core_regfile
  import cpu_core_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_1,
  input  logic [REG_AW-1:0] raddr_2,
  output logic [DATA_W-1:0] rdata_1,
  output logic [DATA_W-1:0] rdata_2
);

  logic [DATA_W-1:0] mem [0:NREGS-1];

  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];

  // Write port, enabled only at the end of a passing execute phase
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// Instruction ROM with a program-load port; the core ties it off.
module cpu_core_rom
  import cpu_core_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] data
);

  logic [INSTR_W-1:0] mem [0:ROM_DEPTH-1];

  assign data = mem[addr];

  // Program-load write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/cpu_core.sv
// Three-phase non-pipelined CPU: fetch -> decode -> execute, one clk each.
// Phase state is held in 'phase' and exposed as fetch_clk/dec_clk/alu_clk.
module cpu_core
  import cpu_core_pkg::*;
(
  input logic clk,
  input logic rst
);

  phase_e             phase;
  logic               fetch_clk;
  logic               dec_clk;
  logic               alu_clk;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] raw_instruction;
  logic [INSTR_W-1:0] rom_data;
  logic [3:0]         op_code;
  cond_e              condition;
  logic [REG_AW-1:0]  dest_reg;
  logic [REG_AW-1:0]  source_reg_one;
  logic [REG_AW-1:0]  source_reg_two;
  flags_t             flags;
  flags_t             alu_flags;
  logic [DATA_W-1:0]  ram_out_data_1;
  logic [DATA_W-1:0]  ram_out_data_2;
  logic [DATA_W-1:0]  ram_in_data_1;
  logic               cond_ok;
  logic               reg_we;

  assign fetch_clk = (phase == PH_FETCH);
  assign dec_clk   = (phase == PH_DEC);
  assign alu_clk   = (phase == PH_EXEC);

  assign cond_ok = cond_pass(condition, flags);
  assign reg_we  = alu_clk && cond_ok && op_writes_reg(op_code);

  cpu_core_rom ROM_i (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc),
    .data  (rom_data)
  );

  cpu_core_regfile RAM_i (
    .clk     (clk),
    .we      (reg_we),
    .waddr   (dest_reg),
    .wdata   (ram_in_data_1),
    .raddr_1 (source_reg_one),
    .raddr_2 (source_reg_two),
    .rdata_1 (ram_out_data_1),
    .rdata_2 (ram_out_data_2)
  );

  cpu_alu alu_i (
    .op     (op_code),
    .a      (ram_out_data_1),
    .b      (ram_out_data_2),
    .shamt  (source_reg_two),
    .result (ram_in_data_1),
    .flags  (alu_flags)
  );

  // Phase sequencer: fetch, latch decoded fields, commit flags on execute
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase           <= PH_FETCH;
      pc              <= '0;
      raw_instruction <= '0;
      op_code         <= '0;
      condition       <= COND_GT;
      dest_reg        <= '0;
      source_reg_one  <= '0;
      source_reg_two  <= '0;
      flags           <= '0;
    end else begin
      case (phase)
        PH_FETCH: begin
          raw_instruction <= rom_data;
          pc              <= pc + 1'b1;
          phase           <= PH_DEC;
        end
        PH_DEC: begin
          op_code        <= raw_instruction[OP_MSB:OP_LSB];
          condition      <= cond_e'(raw_instruction[COND_MSB:COND_LSB]);
          dest_reg       <= raw_instruction[DEST_MSB:DEST_LSB];
          source_reg_one <= raw_instruction[SRC1_MSB:SRC1_LSB];
          source_reg_two <= raw_instruction[SRC2_MSB:SRC2_LSB];
          phase          <= PH_EXEC;
        end
        PH_EXEC: begin
          if (cond_ok && op_sets_flags(op_code)) flags <= alu_flags;
          phase <= PH_FETCH;
        end
        default: phase <= PH_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed vector table, multi-cycle corner sequences
// and random programs checked against an arithmetic reference model.
module tb_cpu_core;
  import cpu_core_pkg::*;

  logic clk;
  logic rst;

  cpu_core dut (
    .clk (clk),
    .rst (rst)
  );

  int n_checks;
  int n_errors;
  logic [15:0] exp_q[$];

  logic [7:0]  m_reg [0:15];
  logic [3:0]  m_flags;
  logic [17:0] prog [0:15];

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [3:0] d;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [7:0] exp_r;
    logic [3:0] exp_f;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [17:0] enc(input logic [3:0] op, input logic [1:0] cond,
                                      input logic [3:0] d, input logic [3:0] s1,
                                      input logic [3:0] s2);
    return {op, cond, d, s1, s2};
  endfunction

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [3:0] d,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic [7:0] v1, input logic [7:0] v2,
                              input logic [7:0] exp_r, input logic [3:0] exp_f);
    vec_t v;
    v.name = name; v.op = op; v.d = d; v.s1 = s1; v.s2 = s2;
    v.v1 = v1; v.v2 = v2; v.exp_r = exp_r; v.exp_f = exp_f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset and wipe register file / ROM to a known baseline
  task automatic begin_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      dut.RAM_i.mem[i] = 8'h00;
      dut.ROM_i.mem[i] = enc(OP_NOP, 2'd3, 4'd0, 4'd0, 4'd0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int sgn8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_exec(input logic [17:0] ins);
    int op, cnd, d, s1, k, a, b, r, p, m;
    bit n, z, v, c, take;
    op  = int'(ins[17:14]);
    cnd = int'(ins[13:12]);
    d   = int'(ins[11:8]);
    s1  = int'(ins[7:4]);
    k   = int'(ins[3:0]);
    a   = int'(m_reg[s1]);
    b   = int'(m_reg[k]);
    n = m_flags[3]; z = m_flags[2]; v = m_flags[1]; c = m_flags[0];
    case (cnd)
      0: take = !z && (n == v);
      1: take = (n != v);
      2: take = z;
      default: take = 1'b1;
    endcase
    if (!take || op > 9) return;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin
        r = a + b; c = (r > 255);
        v = (sgn8(a) + sgn8(b) > 127) || (sgn8(a) + sgn8(b) < -128);
      end
      1, 9: begin
        r = a - b; c = (a < b);
        v = (sgn8(a) - sgn8(b) > 127) || (sgn8(a) - sgn8(b) < -128);
      end
      2: begin p = a * b; r = p; c = (p > 255); v = c; end
      3: r = a | b;
      4: r = a & b;
      5: r = a ^ b;
      6: begin
        r = (k >= 8) ? 0 : (a >> k);
        c = (k == 0 || k > 8) ? 1'b0 : 1'(((a >> (k - 1)) & 1));
      end
      7: begin
        r = a << k;
        c = (k == 0 || k > 8) ? 1'b0 : 1'(((a >> (8 - k)) & 1));
      end
      default: begin
        m = k % 8;
        r = (a >> m) | (a << (8 - m));
        c = 1'(((r & 255) >> 7) & 1);
      end
    endcase
    r = r & 255;
    n = (r >= 128);
    z = (r == 0);
    m_flags = {n, z, v, c};
    if (op != 9) m_reg[d] = 8'(r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] e;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;

    // Reset state
    begin_reset();
    run_cycles(2);
    check("rst_pc", 32'(dut.pc), 32'h0);
    check("rst_flags", 32'(dut.flags), 32'h0);
    check("rst_raw", 32'(dut.raw_instruction), 32'h0);
    check("rst_phase_fetch", 32'(dut.fetch_clk), 32'h1);
    release_reset();
    run_cycles(1);
    check("phase_dec_after_fetch", 32'(dut.dec_clk), 32'h1);
    run_cycles(1);
    check("phase_exec_after_dec", 32'(dut.alu_clk), 32'h1);

    // Directed single-instruction vectors: {name, op, d, s1, s2, R[s1], R[s2], exp R[d], exp NZVC}
    vecs.push_back(mk("add_basic",    OP_ADD, 4'd3,  4'd1, 4'd2, 8'h05, 8'h03, 8'h08, 4'b0000));
    vecs.push_back(mk("sub_borrow",   OP_SUB, 4'd4,  4'd1, 4'd2, 8'h03, 8'h05, 8'hFE, 4'b1001));
    vecs.push_back(mk("shl_2",        OP_SHL, 4'd7,  4'd1, 4'd2, 8'h81, 8'h00, 8'h04, 4'b0000));
    vecs.push_back(mk("ror_1",        OP_ROR, 4'd8,  4'd1, 4'd1, 8'h81, 8'h00, 8'hC0, 4'b1001));
    vecs.push_back(mk("shr_8",        OP_SHR, 4'd9,  4'd1, 4'd8, 8'h81, 8'h00, 8'h00, 4'b0101));
    vecs.push_back(mk("mul_hi",       OP_MUL, 4'd10, 4'd1, 4'd2, 8'h10, 8'h10, 8'h00, 4'b0111));
    vecs.push_back(mk("add_ovf",      OP_ADD, 4'd5,  4'd1, 4'd2, 8'h7F, 8'h01, 8'h80, 4'b1010));
    vecs.push_back(mk("add_carry",    OP_ADD, 4'd5,  4'd1, 4'd2, 8'hFF, 8'h01, 8'h00, 4'b0101));
    vecs.push_back(mk("sub_ovf",      OP_SUB, 4'd6,  4'd1, 4'd2, 8'h80, 8'h01, 8'h7F, 4'b0010));
    vecs.push_back(mk("xor",          OP_XOR, 4'd11, 4'd1, 4'd2, 8'hF0, 8'hFF, 8'h0F, 4'b0000));
    vecs.push_back(mk("and_zero",     OP_AND, 4'd12, 4'd1, 4'd2, 8'hF0, 8'h0F, 8'h00, 4'b0100));
    vecs.push_back(mk("or",           OP_OR,  4'd13, 4'd1, 4'd2, 8'h80, 8'h01, 8'h81, 4'b1000));
    vecs.push_back(mk("shr_1",        OP_SHR, 4'd14, 4'd1, 4'd1, 8'h81, 8'h00, 8'h40, 4'b0001));
    vecs.push_back(mk("shl_0",        OP_SHL, 4'd15, 4'd1, 4'd0, 8'h81, 8'h00, 8'h81, 4'b1000));
    vecs.push_back(mk("ror_9_mod8",   OP_ROR, 4'd0,  4'd1, 4'd9, 8'h81, 8'h00, 8'hC0, 4'b1001));
    vecs.push_back(mk("mul_lo",       OP_MUL, 4'd3,  4'd1, 4'd2, 8'h0F, 8'h11, 8'hFF, 4'b1000));
    vecs.push_back(mk("shl_9",        OP_SHL, 4'd4,  4'd1, 4'd9, 8'h01, 8'h00, 8'h00, 4'b0100));

    foreach (vecs[i]) begin
      begin_reset();
      dut.RAM_i.mem[vecs[i].s2] = vecs[i].v2;
      dut.RAM_i.mem[vecs[i].s1] = vecs[i].v1;
      dut.ROM_i.mem[0] = enc(vecs[i].op, 2'd3, vecs[i].d, vecs[i].s1, vecs[i].s2);
      release_reset();
      run_cycles(3);
      check({vecs[i].name, "_reg"}, 32'(dut.RAM_i.mem[vecs[i].d]), 32'(vecs[i].exp_r));
      check({vecs[i].name, "_flags"}, 32'(dut.flags), 32'(vecs[i].exp_f));
    end

    // CMP then conditional ADDs
    begin_reset();
    dut.RAM_i.mem[1] = 8'h05;
    dut.RAM_i.mem[2] = 8'h03;
    dut.RAM_i.mem[6] = 8'h77;
    dut.ROM_i.mem[0] = enc(OP_CMP, 2'd3, 4'd1, 4'd1, 4'd2);
    dut.ROM_i.mem[1] = enc(OP_ADD, 2'd0, 4'd5, 4'd1, 4'd2);
    dut.ROM_i.mem[2] = enc(OP_ADD, 2'd1, 4'd6, 4'd1, 4'd2);
    release_reset();
    run_cycles(3);
    check("cmp_r1_kept", 32'(dut.RAM_i.mem[1]), 32'h05);
    check("cmp_flags", 32'(dut.flags), 32'h0);
    run_cycles(6);
    check("gt_taken_r5", 32'(dut.RAM_i.mem[5]), 32'h08);
    check("lt_skipped_r6", 32'(dut.RAM_i.mem[6]), 32'h77);
    check("cmp_r2_kept", 32'(dut.RAM_i.mem[2]), 32'h03);

    // Reset asserted during decode abandons the instruction
    begin_reset();
    dut.RAM_i.mem[1] = 8'h03;
    dut.RAM_i.mem[2] = 8'h05;
    dut.RAM_i.mem[3] = 8'hAA;
    dut.ROM_i.mem[0] = enc(OP_SUB, 2'd3, 4'd4, 4'd1, 4'd2);
    dut.ROM_i.mem[1] = enc(OP_ADD, 2'd3, 4'd3, 4'd1, 4'd2);
    release_reset();
    run_cycles(3);
    check("pre_rst_flags", 32'(dut.flags), 32'h9);
    run_cycles(1);
    check("pre_rst_in_decode", 32'(dut.dec_clk), 32'h1);
    check("pre_rst_pc", 32'(dut.pc), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("midrst_pc", 32'(dut.pc), 32'h0);
    check("midrst_flags", 32'(dut.flags), 32'h0);
    check("midrst_raw", 32'(dut.raw_instruction), 32'h0);
    check("midrst_fetch", 32'(dut.fetch_clk), 32'h1);
    run_cycles(2);
    check("midrst_no_write", 32'(dut.RAM_i.mem[3]), 32'hAA);
    release_reset();
    run_cycles(3);
    check("refetch_rom0_r4", 32'(dut.RAM_i.mem[4]), 32'hFE);
    check("refetch_rom0_flags", 32'(dut.flags), 32'h9);
    check("refetch_r3_untouched", 32'(dut.RAM_i.mem[3]), 32'hAA);
    run_cycles(3);
    check("after_rst_r3", 32'(dut.RAM_i.mem[3]), 32'h08);

    // PC wrap: only ROM[0] increments R0, so 17 instructions hit it twice
    begin_reset();
    dut.RAM_i.mem[15] = 8'h01;
    dut.ROM_i.mem[0] = enc(OP_ADD, 2'd3, 4'd0, 4'd0, 4'd15);
    release_reset();
    run_cycles(48);
    check("wrap16_pc", 32'(dut.pc), 32'h0);
    check("wrap16_r0", 32'(dut.RAM_i.mem[0]), 32'h01);
    run_cycles(3);
    check("wrap17_pc", 32'(dut.pc), 32'h1);
    check("wrap17_r0", 32'(dut.RAM_i.mem[0]), 32'h02);

    // Random programs against the reference model
    for (int rnd = 0; rnd < 6; rnd++) begin
      begin_reset();
      for (int i = 0; i < 16; i++) begin
        m_reg[i] = 8'($urandom_range(0, 255));
        dut.RAM_i.mem[i] = m_reg[i];
        prog[i] = enc(4'($urandom_range(0, 11)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
        dut.ROM_i.mem[i] = prog[i];
      end
      m_flags = 4'h0;
      release_reset();
      for (int k = 0; k < 24; k++) begin
        model_exec(prog[k % 16]);
        exp_q.push_back({prog[k % 16][11:8], m_flags, m_reg[prog[k % 16][11:8]]});
        run_cycles(3);
        e = exp_q.pop_front();
        check("rand_exec", 32'({dut.flags, dut.RAM_i.mem[e[15:12]]}), 32'(e[11:0]));
      end
      for (int i = 0; i < 16; i++) begin
        check("rand_regfile", 32'(dut.RAM_i.mem[i]), 32'(m_reg[i]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Minimal three-phase, non-pipelined 8-bit register-to-register CPU.
- Fetches 18-bit instructions from a 16-entry instruction ROM.
- Decodes opcode, condition and register fields, then executes an ALU operation on a 16 x 8-bit register file, updating NZVC flags.
- Top of the processor hierarchy. The bench preloads both memories and probes internal signals by name.

Parameters:
- DATA_W, 8, register and ALU width.
- NREGS, 16, register file depth (4-bit register index).
- ROM_DEPTH, 16, instruction ROM depth (4-bit PC).
- INSTR_W, 18, instruction width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.

Behaviour:
- Instruction fields:
  - [17:14] op_code
  - [13:12] condition
  - [11:8] dest_reg
  - [7:4] source_reg_one
  - [3:0] source_reg_two; the same field is bits_to_shift for shift/rotate ops.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR
  - 0110 SHR (logical), 0111 SHL, 1000 ROR (by bits_to_shift, 0..15, amount taken mod 8 for ROR)
  - 1001 CMP
  - 1010-1111 NOP: no write, no flag change.
- Conditions (evaluated against current flags):
  - 00 GT = !Z & (N==V)
  - 01 LT = N!=V
  - 10 EQ = Z
  - 11 always
  - If the condition is false: no register write, no flag update.
- Phase sequencer: one-hot strobes fetch_clk → dec_clk → alu_clk → fetch_clk, one clk each. One instruction per 3 cycles.
- FETCH: raw_instruction <= ROM[pc]; pc <= pc+1, wrapping 15→0.
- DECODE: latch the fields. ram_out_data_1 = R[source_reg_one] and ram_out_data_2 = R[source_reg_two] are read combinationally.
- EXECUTE:
  - ram_in_data_1 = ALU result (combinational).
  - At the rising edge ending the execute cycle, write R[dest_reg] (except CMP/NOP) and update NZVC.
- Flags:
  - N = result[7]; Z = (result==0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB/CMP: result = a-b; C = borrow (a<b unsigned); V = signed overflow.
  - MUL: result = low byte of the product; C = V = (high byte != 0).
  - Logic ops: C = V = 0.
  - SHR/SHL: C = last bit shifted out (0 if amount is 0); V = 0. Amounts ≥8 give result 0.
  - ROR: C = result[7]; V = 0.
- All 16 registers are general purpose, including R0.
- Reset, asynchronous and effective mid-instruction:
  - pc = 0, phase = fetch, raw_instruction = 0, all decoded fields 0, NZVC = 0000.
  - An in-flight instruction is abandoned with no write.
  - Register file and ROM contents are NOT cleared. They are preloaded by simulation memory load.
- Read-after-write: an instruction sees the value written by the previous instruction, because a full fetch cycle intervenes.

Decomposition:
- Shared package: opcode constants, condition constants, field bit positions, DATA_W/INSTR_W.
- Storage instances are named RAM_i (register file, array mem[0:15] of 8 bits) and ROM_i (array mem[0:15] of 18 bits) so the bench can preload them hierarchically.
- The natural sub-module is cpu_alu: combinational, takes op, a, b and shift amount, produces result and NZVC.

Test Plan:
- R1=5, R2=3, ROM[0]=ADD always R3,R1,R2 → after 3 clk, R3=8, NZVC=0000.
- R1=3, R2=5, SUB always R4,R1,R2 → R4=0xFE, N=1, Z=0, V=0, C=1.
- R1=5, R2=3: CMP R1,R2 then ADD GT R5,R1,R2 then ADD LT R6,R1,R2 → R5=8, R6 unchanged, R1/R2 unchanged by CMP.
- R1=0x81: SHL R7,R1,#2 → R7=0x04, C=0. ROR R8,R1,#1 → R8=0xC0, C=1. SHR R9,R1,#8 → R9=0x00, Z=1.
- R1=0x10, R2=0x10: MUL R10,R1,R2 → R10=0x00, Z=1, C=V=1.
- Assert rst during a decode phase → pc=0, flags 0000, no write; after release, ROM[0] is re-fetched. Run 17 instructions → pc wraps and ROM[0] re-executes.
